// File: rtl/cp0_exc_unit.sv
// -----------------------------------------------------------------------------
// cp0_exc_unit
//
// Coprocessor-0 exception / interrupt unit. Holds SR, Cause, EPC and PRId,
// decides (combinationally) whether the M-stage instruction must be flushed for
// an interrupt or exception, and supplies the redirect PC for both exception
// entry and eret.
//
// Optional feature: define CP0_TIMER_EN to add the Count(9) / Compare(11)
// timer. Its sticky match flag is ORed into Cause.IP[15]. With the macro
// undefined, registers 9 and 11 read 0 and ignore writes.
//
// Ports
//   clk          in   1   single clock, all state on rising edge
//   reset        in   1   asynchronous, active-low; clears all state
//   pc_in        in   32  PC of the M-stage instruction
//   bd_in        in   1   M-stage instruction sits in a branch delay slot
//   exc_valid    in   1   exception flag from the E-stage selector (via E/M)
//   exc_code_in  in   5   ExcCode from the E-stage selector (via E/M)
//   hw_int       in   6   external interrupt lines, level sensitive
//   we           in   1   mtc0 write enable
//   addr         in   5   CP0 register number for mtc0/mfc0
//   wdata        in   32  mtc0 data
//   eret         in   1   M-stage instruction is eret
//   rdata        out  32  mfc0 read data, combinational from addr
//   take_exc     out  1   flush pipeline and redirect this cycle
//   exc_pc       out  32  EXC_VECTOR when take_exc, else EPC (eret target)
//   epc_out      out  32  current EPC
// -----------------------------------------------------------------------------
module cp0_exc_unit #(
    parameter logic [31:0] PRID       = 32'h0000_2019,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic        bd_in,
    input  logic        exc_valid,
    input  logic [4:0]  exc_code_in,
    input  logic [5:0]  hw_int,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    input  logic        eret,
    output logic [31:0] rdata,
    output logic        take_exc,
    output logic [31:0] exc_pc,
    output logic [31:0] epc_out
);

    localparam logic [4:0] ADDR_COUNT   = 5'd9;
    localparam logic [4:0] ADDR_COMPARE = 5'd11;
    localparam logic [4:0] ADDR_SR      = 5'd12;
    localparam logic [4:0] ADDR_CAUSE   = 5'd13;
    localparam logic [4:0] ADDR_EPC     = 5'd14;
    localparam logic [4:0] ADDR_PRID    = 5'd15;

    // Architectural state: SR fields
    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    // Cause fields
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exc_code_q, exc_code_d;
    // EPC
    logic [31:0] epc_q, epc_d;

`ifdef CP0_TIMER_EN
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        timer_pend_q, timer_pend_d;
`endif

    // Decision signals
    logic [5:0]  ip_eff;
    logic        irq;
    logic        wr_en;
    logic [31:0] victim_pc;
    logic [31:0] sr_word;
    logic [31:0] cause_word;

    // -------------------------------------------------------------------------
    // Interrupt / exception decision (zero-latency, from registered SR)
    // -------------------------------------------------------------------------
    always_comb begin
        ip_eff = ip_q;
`ifdef CP0_TIMER_EN
        // The timer match is visible in IP[15] as soon as it is flagged, so
        // the interrupt is seen the cycle after the flag sets.
        ip_eff[5] = ip_q[5] | timer_pend_q;
`endif
        irq = (|(ip_eff & im_q)) & ie_q & ~exl_q;
        // Gate with reset so no flush request escapes while the unit is held
        // in reset (exc_valid itself is not cleared by our reset).
        take_exc = reset & (irq | (exc_valid & ~exl_q));
    end

    assign exc_pc  = take_exc ? EXC_VECTOR : epc_q;
    assign epc_out = epc_q;

    // -------------------------------------------------------------------------
    // Read mux (no bypass: reads always see the registered value)
    // -------------------------------------------------------------------------
    assign sr_word    = {16'h0000, im_q, 8'h00, exl_q, ie_q};
    assign cause_word = {bd_q, 15'h0000, ip_eff, 3'b000, exc_code_q, 2'b00};

    always_comb begin
        rdata = 32'h0000_0000;
        case (addr)
            ADDR_SR:      rdata = sr_word;
            ADDR_CAUSE:   rdata = cause_word;
            ADDR_EPC:     rdata = epc_q;
            ADDR_PRID:    rdata = PRID;
`ifdef CP0_TIMER_EN
            ADDR_COUNT:   rdata = count_q;
            ADDR_COMPARE: rdata = compare_q;
`endif
            default:      rdata = 32'h0000_0000;
        endcase
    end

    // -------------------------------------------------------------------------
    // Next-state logic. Priority, lowest to highest: mtc0, eret, exception.
    // -------------------------------------------------------------------------
    assign victim_pc = bd_in ? (pc_in - 32'd4) : pc_in;

    always_comb begin
        // NOTE: every variable gets a default before any branch so that no
        // path leaves it unassigned; otherwise synthesis infers a latch.
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ip_d       = hw_int;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;

        // A taken exception/interrupt squashes the same-cycle mtc0.
        wr_en = we & ~take_exc;

        if (wr_en) begin
            case (addr)
                ADDR_SR: begin
                    im_d  = wdata[15:10];
                    exl_d = wdata[1];
                    ie_d  = wdata[0];
                end
                ADDR_EPC: epc_d = {wdata[31:2], 2'b00};
                default:  ;
            endcase
        end

        if (eret && !take_exc) begin
            exl_d = 1'b0;
        end

        if (take_exc) begin
            exl_d      = 1'b1;
            exc_code_d = irq ? 5'd0 : exc_code_in;
            bd_d       = bd_in;
            epc_d      = {victim_pc[31:2], 2'b00};
        end
    end

`ifdef CP0_TIMER_EN
    always_comb begin
        count_d      = count_q + 32'd1;
        compare_d    = compare_q;
        timer_pend_d = timer_pend_q | (count_q == compare_q);

        if (wr_en && (addr == ADDR_COUNT)) begin
            count_d = wdata;
        end
        // Rewriting Compare is the only way to acknowledge the timer; the
        // clear wins over a match in the same cycle.
        if (wr_en && (addr == ADDR_COMPARE)) begin
            compare_d    = wdata;
            timer_pend_d = 1'b0;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im_q       <= 6'd0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_q       <= 6'd0;
            exc_code_q <= 5'd0;
            epc_q      <= 32'h0000_0000;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // flop samples the pre-edge values regardless of statement order.
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ip_q       <= ip_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
        end
    end

`ifdef CP0_TIMER_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q      <= 32'h0000_0000;
            compare_q    <= 32'h0000_0000;
            timer_pend_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            compare_q    <= compare_d;
            timer_pend_q <= timer_pend_d;
        end
    end
`endif

endmodule

// File: tb/tb_cp0_exc_unit.sv
// -----------------------------------------------------------------------------
// tb_cp0_exc_unit
//
// Directed scenarios followed by randomized traffic, all compared against a
// word-level model of the CP0 registers kept in this file.
// -----------------------------------------------------------------------------
module tb_cp0_exc_unit;

    localparam logic [31:0] PRID_VAL = 32'h0000_2019;
    localparam logic [31:0] VEC      = 32'h0000_4180;
`ifdef CP0_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif
    // Timer flag visible in Cause once it has set (only in the timer build).
    localparam logic [31:0] TP = TIMER ? 32'h0000_8000 : 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in;
    logic        bd_in;
    logic        exc_valid;
    logic [4:0]  exc_code_in;
    logic [5:0]  hw_int;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        eret;
    logic [31:0] rdata;
    logic        take_exc;
    logic [31:0] exc_pc;
    logic [31:0] epc_out;

    int vectors     = 0;
    int miscompares = 0;

    cp0_exc_unit dut (
        .clk         (clk),
        .reset       (reset),
        .pc_in       (pc_in),
        .bd_in       (bd_in),
        .exc_valid   (exc_valid),
        .exc_code_in (exc_code_in),
        .hw_int      (hw_int),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .eret        (eret),
        .rdata       (rdata),
        .take_exc    (take_exc),
        .exc_pc      (exc_pc),
        .epc_out     (epc_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model: registers kept as whole 32-bit words
    // -------------------------------------------------------------------------
    logic [31:0] m_sr, m_cause, m_epc, m_count, m_compare;
    bit          m_tpend;

    task automatic model_reset();
        m_sr = 0; m_cause = 0; m_epc = 0; m_count = 0; m_compare = 0; m_tpend = 0;
    endtask

    function automatic logic [31:0] m_cause_view();
        return (TIMER && m_tpend) ? (m_cause | 32'h0000_8000) : m_cause;
    endfunction

    function automatic bit m_irq();
        bit pend;
        pend = ((m_cause_view() & m_sr & 32'h0000_FC00) != 0);
        return pend && m_sr[0] && !m_sr[1];
    endfunction

    function automatic bit m_take();
        return reset && (m_irq() || (exc_valid && !m_sr[1]));
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause_view();
            5'd14:   return m_epc;
            5'd15:   return PRID_VAL;
            5'd9:    return TIMER ? m_count : 32'h0;
            5'd11:   return TIMER ? m_compare : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    // Check all outputs against the model, away from the active edge.
    task automatic sample();
        @(negedge clk);
        check("take_exc", {31'b0, take_exc}, {31'b0, m_take()});
        check("exc_pc", exc_pc, m_take() ? VEC : m_epc);
        check("epc_out", epc_out, m_epc);
        check($sformatf("rdata@%0d", addr), rdata, m_read(addr));
    endtask

    // Apply one clock edge to both the DUT and the model.
    task automatic advance();
        bit          t, irq;
        bit          wr;
        logic [31:0] n_sr, n_cause, n_epc, n_count, n_compare;
        bit          n_tpend;
        t   = m_take();
        irq = m_irq();
        wr  = we && !t;
        n_sr    = m_sr;
        n_epc   = m_epc;
        n_cause = (m_cause & ~32'h0000_FC00) | ({26'b0, hw_int} << 10);
        if (t) begin
            n_sr    = n_sr | 32'h2;
            n_cause = (n_cause & ~32'h8000_007C)
                    | (bd_in ? 32'h8000_0000 : 32'h0)
                    | ({27'b0, (irq ? 5'd0 : exc_code_in)} << 2);
            n_epc   = (bd_in ? pc_in - 32'd4 : pc_in) & ~32'h3;
        end else begin
            if (wr && addr == 5'd12) n_sr  = wdata & 32'h0000_FC03;
            if (wr && addr == 5'd14) n_epc = wdata & ~32'h3;
            if (eret) n_sr = n_sr & ~32'h2;
        end
        n_count   = (wr && addr == 5'd9) ? wdata : m_count + 32'd1;
        n_compare = (wr && addr == 5'd11) ? wdata : m_compare;
        n_tpend   = (wr && addr == 5'd11) ? 1'b0 : (m_tpend || (m_count == m_compare));
        @(posedge clk);
        #1;
        m_sr = n_sr; m_cause = n_cause; m_epc = n_epc;
        m_count = n_count; m_compare = n_compare; m_tpend = n_tpend;
    endtask

    task automatic idle();
        we = 0; eret = 0; exc_valid = 0; bd_in = 0; pc_in = 0;
        addr = 0; wdata = 0; exc_code_in = 0; hw_int = 0;
    endtask

    task automatic cycle_rd(input logic [4:0] a, input string tag, input logic [31:0] exp);
        addr = a;
        sample();
        check(tag, rdata, exp);
        advance();
    endtask

    // Asynchronous reset in the middle of a cycle, released just after an edge.
    task automatic apply_reset();
        @(posedge clk);
        #2;
        reset = 0;
        exc_valid = 1; we = 1; addr = 5'd14; wdata = 32'hFFFF_FFFF;
        #1;
        check("rst_take_exc", {31'b0, take_exc}, 32'h0);
        check("rst_exc_pc", exc_pc, 32'h0);
        check("rst_epc_out", epc_out, 32'h0);
        check("rst_epc_rd", rdata, 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        idle();
        #1;
        reset = 1;
    endtask

    initial begin
        reset = 0;
        idle();
        apply_reset();

        // ---- Reset values
        cycle_rd(5'd13, "t1_cause", 32'h0);
        cycle_rd(5'd12, "t1_sr", 32'h0);
        cycle_rd(5'd14, "t1_epc", 32'h0);
        cycle_rd(5'd15, "t1_prid", PRID_VAL);

        // ---- Plain exception (RI)
        exc_valid = 1; exc_code_in = 5'd10; pc_in = 32'h3010; bd_in = 0;
        sample();
        check("t2_take", {31'b0, take_exc}, 32'h1);
        check("t2_exc_pc", exc_pc, VEC);
        advance();
        idle();
        cycle_rd(5'd13, "t2_cause", 32'h0000_0028 | TP);
        cycle_rd(5'd14, "t2_epc", 32'h3010);
        cycle_rd(5'd12, "t2_sr", 32'h2);

        // ---- Delay-slot exception, then one ignored while EXL=1
        eret = 1;
        sample();
        check("t3_eret_pc", exc_pc, 32'h3010);
        advance();
        idle();
        exc_valid = 1; exc_code_in = 5'd10; pc_in = 32'h3020; bd_in = 1;
        sample();
        check("t3_take", {31'b0, take_exc}, 32'h1);
        advance();
        idle();
        cycle_rd(5'd14, "t3_epc", 32'h301C);
        cycle_rd(5'd13, "t3_cause", 32'h8000_0028 | TP);
        exc_valid = 1; exc_code_in = 5'd12; pc_in = 32'h5000; bd_in = 0;
        sample();
        check("t3_masked", {31'b0, take_exc}, 32'h0);
        advance();
        idle();
        cycle_rd(5'd13, "t3_cause_kept", 32'h8000_0028 | TP);
        cycle_rd(5'd14, "t3_epc_kept", 32'h301C);

        // ---- Interrupt beats a same-cycle exception
        eret = 1;
        sample(); advance();
        idle();
        we = 1; addr = 5'd12; wdata = 32'h0000_0401;
        sample(); advance();
        idle();
        hw_int = 6'b000001;
        sample(); advance();
        exc_valid = 1; exc_code_in = 5'd12; pc_in = 32'h3100;
        sample();
        check("t4_take", {31'b0, take_exc}, 32'h1);
        advance();
        exc_valid = 0; exc_code_in = 0; pc_in = 0;
        cycle_rd(5'd13, "t4_cause", 32'h0000_0400 | TP);

        // ---- eret together with mtc0 SR; then exception drops the write
        idle();
        eret = 1; we = 1; addr = 5'd12; wdata = 32'h0000_7C01;
        sample();
        check("t5_eret_pc", exc_pc, 32'h3100);
        check("t5_no_take", {31'b0, take_exc}, 32'h0);
        advance();
        idle();
        cycle_rd(5'd12, "t5_sr", 32'h0000_7C01);
        eret = 1; we = 1; addr = 5'd12; wdata = 32'h0000_0001;
        exc_valid = 1; exc_code_in = 5'd10; pc_in = 32'h3200;
        sample();
        check("t5_exc_wins", exc_pc, VEC);
        advance();
        idle();
        cycle_rd(5'd12, "t5_sr_drop", 32'h0000_7C03);

        // ---- Reset in the middle of a handler
        apply_reset();
        cycle_rd(5'd13, "t7_cause", 32'h0);
        cycle_rd(5'd12, "t7_sr", 32'h0);
        cycle_rd(5'd14, "t7_epc", 32'h0);

`ifdef CP0_TIMER_EN
        // ---- Timer interrupt
        apply_reset();
        we = 1; addr = 5'd11; wdata = 32'd5;
        sample(); advance();
        we = 1; addr = 5'd9; wdata = 32'd0;
        sample(); advance();
        for (int k = 0; k <= 8; k++) begin
            idle();
            if (k == 0) begin
                we = 1; addr = 5'd12; wdata = 32'h0000_8001;
            end
            sample();
            check($sformatf("t6_take_k%0d", k), {31'b0, take_exc}, (k == 6) ? 32'h1 : 32'h0);
            advance();
        end
        idle();
        cycle_rd(5'd13, "t6_pend", (32'h0000_8000 | (32'd0 << 2)));
        we = 1; addr = 5'd11; wdata = 32'd1000;
        sample(); advance();
        idle();
        cycle_rd(5'd13, "t6_cleared", 32'h0);
`endif

        // ---- Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [4:0] pick [7];
            pick = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0};
            idle();
            addr        = ($urandom_range(0, 3) == 0) ? 5'($urandom) : pick[$urandom_range(0, 5)];
            we          = ($urandom_range(0, 5) == 0);
            wdata       = $urandom;
            eret        = ($urandom_range(0, 7) == 0);
            exc_valid   = ($urandom_range(0, 7) == 0);
            exc_code_in = 5'($urandom);
            pc_in       = $urandom;
            bd_in       = 1'($urandom);
            hw_int      = 6'($urandom & $urandom & $urandom);
            sample();
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
